// File: rtl/multu_seq.sv
// Sequential unsigned shift-add multiplier producing a 2*WIDTH product into hi/lo.
// Optional MULTU_EARLY_EXIT_EN ends the iteration once the remaining multiplier is zero.
module multu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned      PW       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    mcand, mcand_next;
  logic [PW-1:0]    acc, acc_next;
  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] mplier, mplier_next, mplier_shr;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic             busy_next, done_next;
  logic             last_iter;

  // One shift-add step; the 2*WIDTH accumulator cannot overflow for unsigned operands.
  assign sum        = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shr = mplier >> 1;

`ifdef MULTU_EARLY_EXIT_EN
  assign last_iter = (cnt == LAST_CNT) || (mplier_shr == '0);
`else
  assign last_iter = (cnt == LAST_CNT);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start)     state_next = ST_RUN;
      ST_RUN:  if (last_iter) state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    cnt_next    = cnt;
    hi_next     = hi;
    lo_next     = lo;
    busy_next   = (state_next == ST_RUN);
    done_next   = (state_next == ST_DONE);
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          mcand_next  = {{WIDTH{1'b0}}, dataA};
          mplier_next = dataB;
          acc_next    = '0;
          cnt_next    = '0;
        end
      end
      ST_RUN: begin
        acc_next    = sum;
        mcand_next  = mcand << 1;
        mplier_next = mplier_shr;
        cnt_next    = cnt + CNT_W'(1);
        // Final sum goes straight to hi/lo so partial sums are never visible.
        if (last_iter) begin
          hi_next = sum[PW-1:WIDTH];
          lo_next = sum[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      hi     <= hi_next;
      lo     <= lo_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// Randomized self-checking bench for multu_seq against an arithmetic product/latency model.
// Latency expectations follow MULTU_EARLY_EXIT_EN when it is defined for the build.
module tb_multu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          failures;
  logic [63:0] prod_q;

  multu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dataA (dataA),
    .dataB (dataB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Clocks from accept edge to done edge, derived from the multiplier value alone.
  function automatic int model_lat(input logic [31:0] b);
    int lat;
`ifdef MULTU_EARLY_EXIT_EN
    lat = 1;
    for (int i = 0; i < 32; i++)
      if (b[i]) lat = i + 1;
`else
    lat = 32;
`endif
    return lat;
  endfunction

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [63:0] exp_p;
    int          exp_lat;
    int          n;
    bit          bad_busy;
    bit          bad_hold;
    bit          extra_done;
    exp_p      = {32'b0, a} * {32'b0, b};
    exp_lat    = model_lat(b);
    bad_busy   = 1'b0;
    bad_hold   = 1'b0;
    extra_done = 1'b0;
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    n = 0;
    while (!done && n < 200) begin
      if (!busy) bad_busy = 1'b1;
      if ({hi, lo} !== prod_q) bad_hold = 1'b1;
      if (poke && n == 3) begin
        dataA = 32'd9;
        dataB = 32'd9;
        start = 1'b1;
      end
      if (poke && n == 4) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (n >= 200) begin
      check("done_timeout", 64'(n), 64'(exp_lat));
      return;
    end
    check("busy_in_run", 64'(bad_busy), 64'd0);
    check("hilo_hold_in_run", 64'(bad_hold), 64'd0);
    check("latency", 64'(n), 64'(exp_lat));
    check("product", {hi, lo}, exp_p);
    check("busy_at_done", 64'(busy), 64'd0);
    prod_q = exp_p;
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    if (poke) begin
      for (int i = 0; i < 40; i++) begin
        if (done) extra_done = 1'b1;
        @(posedge clk); #1;
      end
      check("dropped_start_no_done", 64'(extra_done), 64'd0);
      check("dropped_start_hilo", {hi, lo}, exp_p);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    checks   = 0;
    failures = 0;
    prod_q   = '0;
    rst      = 1'b0;
    start    = 1'b0;
    dataA    = '0;
    dataB    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_mul(32'd3, 32'd5, 1'b0);
    check("basic_3x5", {hi, lo}, 64'd15);

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("max_lo", 64'(lo), 64'h0000_0001);

    run_mul(32'h0001_0000, 32'h0001_0000, 1'b1);
    check("busy_start_result", {hi, lo}, 64'h0000_0001_0000_0000);

    run_mul(32'd0, 32'hDEAD_BEEF, 1'b0);
    run_mul(32'h1234_5678, 32'd0, 1'b0);

    // Abort a 7*7 part-way through RUN.
    dataA = 32'd7;
    dataB = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    prod_q = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_mul(32'd2, 32'd4, 1'b0);
    check("after_abort_2x4", {hi, lo}, 64'd8);

    run_mul(32'd6, 32'd7, 1'b0);
    check("b2b_first", {hi, lo}, 64'd42);
    run_mul(32'h8000_0000, 32'd2, 1'b0);
    check("b2b_second", {hi, lo}, 64'h0000_0001_0000_0000);

`ifdef MULTU_EARLY_EXIT_EN
    run_mul(32'd7, 32'd2, 1'b0);
    check("ee_7x2", {hi, lo}, 64'd14);
    run_mul(32'd5, 32'd0, 1'b0);
    check("ee_5x0", {hi, lo}, 64'd0);
`endif

    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      run_mul(ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multu_seq.md
Name: multu_seq

Overview:
- Sequential unsigned shift-add multiplier. Sits in the execute stage beside the logical-left barrel shifter, and uses the same shift-and-add datapath idiom.
- Consumes the same dataA/dataB operands as the shifter.
- Produces a 2*WIDTH product into HI/LO registers, which the MFHI/MFLO path reads.
- The controller drives it with a start/busy/done handshake and stalls while busy.

Parameters:
- WIDTH, 32, operand width. hi and lo are each WIDTH bits wide.
- CNT_W, 6, iteration-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request a multiply; sampled only in IDLE
- dataA  input  WIDTH  multiplicand; latched on accepted start
- dataB  input  WIDTH  multiplier; latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  WIDTH  upper half of the last completed product
- lo  output  WIDTH  lower half of the last completed product

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Internal multiplicand (2*WIDTH), multiplier, accumulator and counter all cleared.
  - Reset mid-RUN aborts the multiply: no done, hi/lo forced to 0.
- States: IDLE, RUN, DONE. State, busy, done, hi and lo are all registered.
- IDLE:
  - On a clock edge with start=1: mcand={WIDTH'b0,dataA}, mplier=dataB, acc=0, cnt=0; go to RUN.
  - start=0: stay in IDLE, outputs hold.
- RUN, one iteration per clock:
  - If mplier[0]: acc=acc+mcand, modulo 2^(2*WIDTH); carry-out discarded, never occurs for unsigned inputs.
  - Then mcand=mcand<<1, mplier=mplier>>1, cnt=cnt+1.
  - When cnt==WIDTH-1 at the edge, the final sum is written directly to {hi,lo} and the state moves to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE and in RUN; it is not queued.
- Latency:
  - Start sampled at edge E0; busy=1 after E0 through E_WIDTH.
  - hi/lo valid and done=1 after edge E_WIDTH. Default: 32 clocks from start-accept edge to done.
  - done deasserts, and start is accepted again, from edge E_WIDTH+1.
- hi/lo hold the last completed product until the next completion. They never show partial sums.
- dataA/dataB may change freely after the accept edge without affecting the result.
- Boundary values:
  - dataB=0 or dataA=0 gives hi=lo=0 with full latency.
  - All-ones operands must not overflow the 2*WIDTH accumulator.

Optional Feature:
- Macro: MULTU_EARLY_EXIT_EN.
- Defined:
  - RUN also exits to DONE at the end of any iteration where the shifted mplier becomes 0.
  - RUN cycles = max(1, index of highest set bit of dataB + 1).
  - Result, done pulse and hi/lo update rules are unchanged.
- Undefined: fixed WIDTH RUN iterations, no zero-detect logic.

Test Plan:
- Basic multiply: dataA=3, dataB=5, start for 1 cycle.
  - Expect hi=0, lo=15.
  - busy high for 32 cycles; done high exactly 1 cycle, 32 edges after accept.
- Max operands: dataA=dataB=0xFFFFFFFF.
  - Expect hi=0xFFFFFFFE, lo=0x00000001.
- Start while busy: start at accept, then dataA=9, dataB=9, start=1 during RUN.
  - Expect the original 0x00010000*0x00010000 to give hi=0x00000001, lo=0.
  - No second done pulse; the new request is dropped.
- Reset mid-operation: rst=0 at RUN cycle 10 of 7*7.
  - Expect immediate busy=0, done=0, hi=lo=0.
  - After release, a new 2*4 gives lo=8 with full latency.
- Back-to-back: 6*7 then 0x80000000*2, second start asserted in the first cycle after done.
  - Expect lo=42, then hi=1, lo=0; hi/lo hold 42 until the second done.
- MULTU_EARLY_EXIT_EN defined:
  - 7*2: done 2 edges after accept, lo=14.
  - 5*0: done 1 edge after accept, hi=lo=0.
